mips_controller: RTL and testbench

//  Multicycle Moore FSM that sequences the 8-bit MIPS datapath.

---
 rtl/mips_controller.sv | 164 ++++++++++++++++
 tb/tb_mips_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mips_controller.sv
// Multicycle Moore controller for the 8-bit MIPS datapath.
// It fetches four instruction bytes, decodes op/funct and sequences the execute/writeback states.
module mips_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       memtoreg,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic       regdst,
    output logic       regwrite,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] F1   = 4'd1;
    localparam logic [3:0] F2   = 4'd2;
    localparam logic [3:0] F3   = 4'd3;
    localparam logic [3:0] F4   = 4'd4;
    localparam logic [3:0] DEC  = 4'd5;
    localparam logic [3:0] MADR = 4'd6;
    localparam logic [3:0] LBRD = 4'd7;
    localparam logic [3:0] LBWR = 4'd8;
    localparam logic [3:0] SBWR = 4'd9;
    localparam logic [3:0] REX  = 4'd10;
    localparam logic [3:0] RWR  = 4'd11;
    localparam logic [3:0] BEQX = 4'd12;
    localparam logic [3:0] JEX  = 4'd13;
    localparam logic [3:0] AIEX = 4'd14;
    localparam logic [3:0] AIWR = 4'd15;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic       pcwrite;
    logic       branch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = F1;
        case (state_reg)
            IDLE: state_next = F1;
            F1:   state_next = F2;
            F2:   state_next = F3;
            F3:   state_next = F4;
            F4:   state_next = DEC;
            DEC: begin
                case (op)
                    OP_RTYPE:     state_next = REX;
                    OP_LB, OP_SB: state_next = MADR;
                    OP_BEQ:       state_next = BEQX;
                    OP_J:         state_next = JEX;
                    OP_ADDI:      state_next = AIEX;
                    default:      state_next = F1;
                endcase
            end
            // op is re-examined here; anything other than LB is taken as a store
            MADR: state_next = (op == OP_LB) ? LBRD : SBWR;
            LBRD: state_next = LBWR;
            REX:  state_next = RWR;
            AIEX: state_next = AIWR;
            default: state_next = F1;
        endcase
    end

    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        irwrite    = 4'b0000;
        memtoreg   = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        pcsource   = 2'b00;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alucontrol = 3'b000;
        case (state_reg)
            F1, F2, F3, F4: begin
                memread    = 1'b1;
                irwrite    = 4'b0001 << (state_reg - F1);
                alusrcb    = 2'b01;
                pcwrite    = 1'b1;
                alucontrol = ALU_ADD;
            end
            DEC: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
            end
            MADR, AIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            REX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            RWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BEQX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch     = 1'b1;
                pcsource   = 2'b01;
            end
            JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            AIWR: regwrite = 1'b1;
            default: ;
        endcase
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_reg;

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: a vector table walks every instruction class,
// followed by hand-written reset sequences.
module tb_mips_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memread, memwrite, alusrca, iord, memtoreg, pcen, regdst, regwrite;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] irwrite, state;
    logic [2:0] alucontrol;
    logic [18:0] outs;

    int checks = 0;
    int errors = 0;

    mips_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg), .pcen(pcen),
        .pcsource(pcsource), .regdst(regdst), .regwrite(regwrite),
        .alucontrol(alucontrol), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {memread,memwrite,alusrca,alusrcb,iord,irwrite,memtoreg,pcen,pcsource,regdst,regwrite,alucontrol}
    assign outs = {memread, memwrite, alusrca, alusrcb, iord, irwrite,
                   memtoreg, pcen, pcsource, regdst, regwrite, alucontrol};

    localparam logic [18:0] O_NONE = 19'b0_0_0_00_0_0000_0_0_00_0_0_000;
    localparam logic [18:0] O_F1   = 19'b1_0_0_01_0_0001_0_1_00_0_0_010;
    localparam logic [18:0] O_F2   = 19'b1_0_0_01_0_0010_0_1_00_0_0_010;
    localparam logic [18:0] O_F3   = 19'b1_0_0_01_0_0100_0_1_00_0_0_010;
    localparam logic [18:0] O_F4   = 19'b1_0_0_01_0_1000_0_1_00_0_0_010;
    localparam logic [18:0] O_DEC  = 19'b0_0_0_11_0_0000_0_0_00_0_0_010;
    localparam logic [18:0] O_MADR = 19'b0_0_1_10_0_0000_0_0_00_0_0_010;
    localparam logic [18:0] O_LBRD = 19'b1_0_0_00_1_0000_0_0_00_0_0_000;
    localparam logic [18:0] O_LBWR = 19'b0_0_0_00_0_0000_1_0_00_0_1_000;
    localparam logic [18:0] O_SBWR = 19'b0_1_0_00_1_0000_0_0_00_0_0_000;
    localparam logic [18:0] O_REXB = 19'b0_0_1_00_0_0000_0_0_00_0_0_000;
    localparam logic [18:0] O_RWR  = 19'b0_0_0_00_0_0000_0_0_00_1_1_000;
    localparam logic [18:0] O_BEQ1 = 19'b0_0_1_00_0_0000_0_1_01_0_0_110;
    localparam logic [18:0] O_BEQ0 = 19'b0_0_1_00_0_0000_0_0_01_0_0_110;
    localparam logic [18:0] O_JEX  = 19'b0_0_0_00_0_0000_0_1_10_0_0_000;
    localparam logic [18:0] O_AIWR = 19'b0_0_0_00_0_0000_0_0_00_0_1_000;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [18:0] out;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic [3:0] s, input logic [18:0] e);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.st = s; v.out = e;
        vecs.push_back(v);
    endtask

    // F2..DEC of an instruction whose F1 row was already added
    task automatic add_fetch(input logic [5:0] o, input logic [5:0] f, input logic z);
        add(o, f, z, 4'd2, O_F2);
        add(o, f, z, 4'd3, O_F3);
        add(o, f, z, 4'd4, O_F4);
        add(o, f, z, 4'd5, O_DEC);
    endtask

    task automatic add_rtype(input logic [5:0] f, input logic [2:0] alu);
        add_fetch(6'b000000, f, 1'b0);
        add(6'b000000, f, 1'b0, 4'd10, O_REXB | {16'b0, alu});
        add(6'b000000, f, 1'b0, 4'd11, O_RWR);
        add(6'b000000, f, 1'b0, 4'd1,  O_F1);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] st_exp,
                         input logic [18:0] out_exp);
        checks++;
        if (state !== st_exp) begin
            errors++;
            $display("FAIL %s[%0d] state: got %0d expected %0d", name, idx, state, st_exp);
        end
        checks++;
        if (outs !== out_exp) begin
            errors++;
            $display("FAIL %s[%0d] outputs: got %b expected %b", name, idx, outs, out_exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: IDLE -> F1 row, then R-type add
        add(6'b000000, 6'b100000, 1'b0, 4'd1, O_F1);
        add_rtype(6'b100000, 3'b010);
        // LB, 8 cycles
        add_fetch(6'b100000, 6'b0, 1'b0);
        add(6'b100000, 6'b0, 1'b0, 4'd6, O_MADR);
        add(6'b100000, 6'b0, 1'b0, 4'd7, O_LBRD);
        add(6'b100000, 6'b0, 1'b0, 4'd8, O_LBWR);
        add(6'b100000, 6'b0, 1'b0, 4'd1, O_F1);
        // SB
        add_fetch(6'b101000, 6'b0, 1'b0);
        add(6'b101000, 6'b0, 1'b0, 4'd6, O_MADR);
        add(6'b101000, 6'b0, 1'b0, 4'd9, O_SBWR);
        add(6'b101000, 6'b0, 1'b0, 4'd1, O_F1);
        // BEQ taken / not taken
        add_fetch(6'b000100, 6'b0, 1'b1);
        add(6'b000100, 6'b0, 1'b1, 4'd12, O_BEQ1);
        add(6'b000100, 6'b0, 1'b1, 4'd1,  O_F1);
        add_fetch(6'b000100, 6'b0, 1'b0);
        add(6'b000100, 6'b0, 1'b0, 4'd12, O_BEQ0);
        add(6'b000100, 6'b0, 1'b0, 4'd1,  O_F1);
        // unknown opcode acts as NOP
        add_fetch(6'b111111, 6'b0, 1'b0);
        add(6'b111111, 6'b0, 1'b0, 4'd1, O_F1);
        // J
        add_fetch(6'b000010, 6'b0, 1'b0);
        add(6'b000010, 6'b0, 1'b0, 4'd13, O_JEX);
        add(6'b000010, 6'b0, 1'b0, 4'd1,  O_F1);
        // ADDI
        add_fetch(6'b001000, 6'b0, 1'b0);
        add(6'b001000, 6'b0, 1'b0, 4'd14, O_MADR);
        add(6'b001000, 6'b0, 1'b0, 4'd15, O_AIWR);
        add(6'b001000, 6'b0, 1'b0, 4'd1,  O_F1);
        // remaining ALU functions, including an unlisted funct
        add_rtype(6'b100010, 3'b110);
        add_rtype(6'b100100, 3'b000);
        add_rtype(6'b100101, 3'b001);
        add_rtype(6'b101010, 3'b111);
        add_rtype(6'b000111, 3'b010);

        op = 6'b0; funct = 6'b0; zero = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", i, 4'd0, O_NONE);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("released", 0, 4'd0, O_NONE);

        for (int i = 0; i < vecs.size(); i++) begin
            op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
            step();
            check("vec", i, vecs[i].st, vecs[i].out);
            $display("vec %0d: op=%b funct=%b zero=%b state=%0d outs=%b",
                     i, vecs[i].op, vecs[i].funct, vecs[i].zero, state, outs);
        end

        // mid-instruction async reset during REX (slt)
        op = 6'b000000; funct = 6'b101010; zero = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("rex_before_reset", 0, 4'd10, O_REXB | 19'd7);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 0, 4'd0, O_NONE);
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_again", i, 4'd0, O_NONE);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        check("restart", 0, 4'd1, O_F1);
        $display("reset sequence done: state=%0d", state);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
